be_scan_slave: RTL and testbench
================================

# be_scan_slave

- Single-clock, oversampled scan-chain responder.
- Receives the backend scan protocol (sdata, sclkp/sclkn, senable, supdate, sreset) as asynchronous pins and shifts data MSB-first through a CHAIN_LEN-bit chain.
- Drives o_sdata for readback and, on supdate, transfers the chain into a parallel shadow configuration register.
- Sits between the chip scan pads and the `dsp_be` configuration fields (enables, resets, EQ taps). It replaces the two-phase latch chain with logic fully synchronous to the backend digital clock.

## Interface
- CHAIN_LEN, 103: scan chain length in bits.
- SYNC_STAGES, 2: synchronizer flops per scan pin; minimum 2.
- i_clk_dig_be  in  1  backend digital clock; must run ≥8× the scan clock rate.
- i_rst_n  in  1  reset, asynchronous, active-low.
- i_sdata  in  1  serial scan data in (async).
- i_sclkp  in  1  scan phase-1 clock (async); its rise samples i_sdata.
- i_sclkn  in  1  scan phase-2 clock (async); its rise commits the shift.
- i_senable  in  1  shift enable (async).
- i_supdate  in  1  shadow update strobe (async).
- i_sreset  in  1  scan soft reset, active-high (async).
- o_sdata  out  1  serial out, equal to chain[CHAIN_LEN-1].
- o_cfg  out  CHAIN_LEN  shadow configuration register.
- o_cfg_upd  out  1  one-cycle pulse when o_cfg is loaded.
- o_err_phase  out  1  sticky flag: protocol phase violation.
- o_err_len  out  1  sticky flag: update arrived after a shift count ≠ CHAIN_LEN.

## Operation
- Every scan input passes through a SYNC_STAGES flop synchronizer, plus one history flop for rising-edge detection on sclkp, sclkn, supdate and sreset.
- Phase FSM has two states:
  - IDLE → CAPT: on a sclkp rise with senable=1; the synchronized sdata is stored in `hold`.
  - CAPT → IDLE: on a sclkn rise; chain <= {chain[CHAIN_LEN-2:0], hold}, and shift_cnt increments, saturating at CHAIN_LEN+1.
  - A sclkp rise while in CAPT sets o_err_phase; hold is overwritten and the state stays CAPT.
  - A sclkn rise while in IDLE is ignored and is not an error (it is the trailing phase of a senable=0 cycle).
- Because bits enter at LSB and shift up, the first bit scanned ends up in chain[CHAIN_LEN-1]. The MSB is scanned first.
- supdate rise loads o_cfg from chain and pulses o_cfg_upd. o_err_len is set if shift_cnt ∉ {0, CHAIN_LEN}, then shift_cnt clears.
  - An update with zero shifts is legal and reloads the shadow.
- sreset rise clears chain, hold, shift_cnt and o_cfg and returns the FSM to IDLE. Sticky error flags are not cleared.
- Simultaneous events in one cycle, in priority order: sreset > sclkn commit > supdate. An update in the same cycle as a commit loads the post-shift chain.
- senable falling while in CAPT: the pending sclkn commit still occurs.

## Timing
- Reset (i_rst_n=0): chain, hold, o_cfg, shift_cnt = 0; FSM in IDLE; o_sdata, o_cfg_upd, o_err_phase, o_err_len = 0.
- Edge latency: pin rise → detected edge is SYNC_STAGES+1 cycles (3 with defaults).
- Shift: o_sdata reflects a new chain MSB 1 cycle after the detected sclkn edge, i.e. SYNC_STAGES+2 cycles after the pin edge.
- Update: o_cfg and o_cfg_upd are valid SYNC_STAGES+2 cycles after the supdate pin rise. o_cfg_upd lasts exactly 1 cycle.
- The scan master samples o_sdata before its next sclkp rise. The ≥8× clock ratio guarantees settling.
- i_rst_n deasserted mid-scan: the partial chain is lost and the master must rescan.

## Structure
- Package `be_scan_pkg`:
  - phase state enum (IDLE, CAPT);
  - default CHAIN_LEN;
  - `BeScanChainLength` and the field index constants (BeEnAlu, BeRstAlu, BeCfgEqHm1, …), shared with the testbench.
- Sub-module `be_scan_sync`: parameterized synchronizer plus rising-edge detector. It is instantiated once per scan input (one sync-only instance for sdata and senable).

## Test plan
- Reset and idle:
  - Stimulus: assert i_rst_n=0 for 5 cycles with pins toggling, then release.
  - Required: all outputs 0; no o_cfg_upd while pins stay idle.
- Full scan and update:
  - Stimulus: shift 103 bits of 103'h1 << 102 | 'h5A5, MSB first, then supdate.
  - Required: o_cfg equals that value; o_cfg_upd high for exactly 1 cycle; o_err_len=0.
- Readback:
  - Stimulus: after the full scan, shift 103 zeros while sampling o_sdata each cycle.
  - Required: the captured stream equals the previously scanned value, MSB first.
- Short scan:
  - Stimulus: shift 50 bits, then update.
  - Required: o_err_len=1 and stays 1 through a later correct scan; o_cfg still loads.
- Phase error:
  - Stimulus: two sclkp pulses without a sclkn between them.
  - Required: o_err_phase=1; the second sampled bit is committed on the next sclkn.
- Soft reset and collision:
  - Stimulus: load o_cfg=all 1s, then pulse sreset and supdate so both edges arrive in the same cycle.
  - Required: o_cfg=0; no o_cfg_upd pulse.

Source files
------------

// File: rtl/be_scan_pkg.sv
// Shared types and chain layout for the backend scan responder.
// Field indices locate dsp_be configuration bits inside o_cfg.
package be_scan_pkg;

  typedef enum logic {
    PH_IDLE = 1'b0,
    PH_CAPT = 1'b1
  } phase_e;

  localparam int BeScanChainLength = 103;

  localparam int BeEnAlu     = 0;
  localparam int BeRstAlu    = 1;
  localparam int BeEnEq      = 2;
  localparam int BeRstEq     = 3;
  localparam int BeEqTapW    = 8;
  localparam int BeCfgEqHm1  = 4;
  localparam int BeCfgEqH0   = BeCfgEqHm1 + BeEqTapW;
  localparam int BeCfgEqH1   = BeCfgEqH0 + BeEqTapW;
  localparam int BeCfgEqH2   = BeCfgEqH1 + BeEqTapW;

endpackage

// File: rtl/be_scan_sync.sv
// Multi-flop synchronizer with registered rising-edge detect; sync out after STAGES
// cycles, rise pulse STAGES+1 cycles after the pin edge; no backpressure.
module be_scan_sync #(
  parameter int WIDTH  = 1,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] i_async,
  output logic [WIDTH-1:0] o_sync,
  output logic [WIDTH-1:0] o_rise
);

  logic [STAGES-1:0][WIDTH-1:0] sync_q, sync_d;
  logic [WIDTH-1:0]             hist_q, hist_d;
  logic [WIDTH-1:0]             rise_q, rise_d;

  always_comb begin
    sync_d = {sync_q[STAGES-2:0], i_async};
    hist_d = sync_q[STAGES-1];
    rise_d = sync_q[STAGES-1] & ~hist_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      hist_q <= '0;
      rise_q <= '0;
    end else begin
      sync_q <= sync_d;
      hist_q <= hist_d;
      rise_q <= rise_d;
    end
  end

  assign o_sync = sync_q[STAGES-1];
  assign o_rise = rise_q;

endmodule

// File: rtl/be_scan_slave.sv
// Oversampled scan-chain responder feeding the dsp_be shadow config register.
// Shift/update visible SYNC_STAGES+2 cycles after the pin edge; no backpressure.
module be_scan_slave
  import be_scan_pkg::*;
#(
  parameter int CHAIN_LEN   = BeScanChainLength,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 i_clk_dig_be,
  input  logic                 i_rst_n,
  input  logic                 i_sdata,
  input  logic                 i_sclkp,
  input  logic                 i_sclkn,
  input  logic                 i_senable,
  input  logic                 i_supdate,
  input  logic                 i_sreset,
  output logic                 o_sdata,
  output logic [CHAIN_LEN-1:0] o_cfg,
  output logic                 o_cfg_upd,
  output logic                 o_err_phase,
  output logic                 o_err_len
);

  localparam int CNT_W = $clog2(CHAIN_LEN + 2);

  logic [1:0] dat_sync;
  logic [1:0] unused_dat_rise;
  logic       sclkp_rise, sclkn_rise, supdate_rise, sreset_rise;
  logic       unused_sclkp_lvl, unused_sclkn_lvl, unused_supdate_lvl, unused_sreset_lvl;

  be_scan_sync #(.WIDTH(2), .STAGES(SYNC_STAGES)) u_sync_dat (
    .clk(i_clk_dig_be), .rst_n(i_rst_n), .i_async({i_sdata, i_senable}),
    .o_sync(dat_sync), .o_rise(unused_dat_rise)
  );
  be_scan_sync #(.WIDTH(1), .STAGES(SYNC_STAGES)) u_sync_sclkp (
    .clk(i_clk_dig_be), .rst_n(i_rst_n), .i_async(i_sclkp),
    .o_sync(unused_sclkp_lvl), .o_rise(sclkp_rise)
  );
  be_scan_sync #(.WIDTH(1), .STAGES(SYNC_STAGES)) u_sync_sclkn (
    .clk(i_clk_dig_be), .rst_n(i_rst_n), .i_async(i_sclkn),
    .o_sync(unused_sclkn_lvl), .o_rise(sclkn_rise)
  );
  be_scan_sync #(.WIDTH(1), .STAGES(SYNC_STAGES)) u_sync_supdate (
    .clk(i_clk_dig_be), .rst_n(i_rst_n), .i_async(i_supdate),
    .o_sync(unused_supdate_lvl), .o_rise(supdate_rise)
  );
  be_scan_sync #(.WIDTH(1), .STAGES(SYNC_STAGES)) u_sync_sreset (
    .clk(i_clk_dig_be), .rst_n(i_rst_n), .i_async(i_sreset),
    .o_sync(unused_sreset_lvl), .o_rise(sreset_rise)
  );

  logic sdata_s, senable_s;
  assign sdata_s   = dat_sync[1];
  assign senable_s = dat_sync[0];

  phase_e               state_q, state_d;
  logic                 hold_q, hold_d;
  logic [CHAIN_LEN-1:0] chain_q, chain_d;
  logic [CHAIN_LEN-1:0] cfg_q, cfg_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 upd_q, upd_d;
  logic                 err_phase_q, err_phase_d;
  logic                 err_len_q, err_len_d;

  always_comb begin
    state_d     = state_q;
    hold_d      = hold_q;
    chain_d     = chain_q;
    cfg_d       = cfg_q;
    cnt_d       = cnt_q;
    upd_d       = 1'b0;
    err_phase_d = err_phase_q;
    err_len_d   = err_len_q;

    if (sreset_rise) begin
      state_d = PH_IDLE;
      hold_d  = 1'b0;
      chain_d = '0;
      cfg_d   = '0;
      cnt_d   = '0;
    end else begin
      if (sclkn_rise && state_q == PH_CAPT) begin
        chain_d = {chain_q[CHAIN_LEN-2:0], hold_q};
        state_d = PH_IDLE;
        if (cnt_q != CNT_W'(CHAIN_LEN + 1)) cnt_d = cnt_q + 1'b1;
      end else if (sclkp_rise) begin
        if (state_q == PH_CAPT) begin
          err_phase_d = 1'b1;
          hold_d      = sdata_s;
        end else if (senable_s) begin
          state_d = PH_CAPT;
          hold_d  = sdata_s;
        end
      end

      // Update sees the post-commit chain and count when both land together.
      if (supdate_rise) begin
        cfg_d = chain_d;
        upd_d = 1'b1;
        if (cnt_d != '0 && cnt_d != CNT_W'(CHAIN_LEN)) err_len_d = 1'b1;
        cnt_d = '0;
      end
    end
  end

  always_ff @(posedge i_clk_dig_be or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= PH_IDLE;
      hold_q      <= 1'b0;
      chain_q     <= '0;
      cfg_q       <= '0;
      cnt_q       <= '0;
      upd_q       <= 1'b0;
      err_phase_q <= 1'b0;
      err_len_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      chain_q     <= chain_d;
      cfg_q       <= cfg_d;
      cnt_q       <= cnt_d;
      upd_q       <= upd_d;
      err_phase_q <= err_phase_d;
      err_len_q   <= err_len_d;
    end
  end

  assign o_sdata     = chain_q[CHAIN_LEN-1];
  assign o_cfg       = cfg_q;
  assign o_cfg_upd   = upd_q;
  assign o_err_phase = err_phase_q;
  assign o_err_len   = err_len_q;

endmodule

// File: tb/tb_be_scan_slave.sv
// Directed bench for be_scan_slave: bit-level scan master driving async pins
// slowly relative to the core clock, with hand-computed expectations.
module tb_be_scan_slave;
  import be_scan_pkg::*;

  localparam int L = BeScanChainLength;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         sdata, sclkp, sclkn, senable, supdate, sreset;
  logic         o_sdata, o_cfg_upd, o_err_phase, o_err_len;
  logic [L-1:0] o_cfg;

  int n_chk = 0;
  int n_err = 0;
  int upd_cnt = 0;

  be_scan_slave u_dut (
    .i_clk_dig_be(clk), .i_rst_n(rst_n), .i_sdata(sdata), .i_sclkp(sclkp),
    .i_sclkn(sclkn), .i_senable(senable), .i_supdate(supdate), .i_sreset(sreset),
    .o_sdata(o_sdata), .o_cfg(o_cfg), .o_cfg_upd(o_cfg_upd),
    .o_err_phase(o_err_phase), .o_err_len(o_err_len)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (o_cfg_upd === 1'b1) upd_cnt++;

  task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One master bit cycle; o_sdata is sampled before the sclkp rise.
  task automatic scan_bit(input logic b, input logic en, output logic so);
    so = o_sdata;
    sdata = b; senable = en;
    wait_cyc(4); sclkp = 1'b1;
    wait_cyc(4); sclkp = 1'b0;
    wait_cyc(4); sclkn = 1'b1;
    wait_cyc(4); sclkn = 1'b0;
    wait_cyc(4);
  endtask

  task automatic scan_word(input logic [L-1:0] v, input int nbits, output logic [L-1:0] cap);
    logic so;
    cap = '0;
    for (int i = nbits - 1; i >= 0; i--) begin
      scan_bit(v[i], 1'b1, so);
      cap[i] = so;
    end
  endtask

  task automatic pulse_update();
    supdate = 1'b1; wait_cyc(8);
    supdate = 1'b0; wait_cyc(8);
  endtask

  logic [L-1:0] val, val2, cap, ones, exp_v;
  int           upd_base;
  logic         so;

  initial begin
    rst_n = 1'b0;
    {sdata, sclkp, sclkn, senable, supdate, sreset} = '0;
    ones = '1;
    val  = '0;
    val[L-1] = 1'b1;
    val[11:0] = 12'h5A5;
    val2 = val ^ ones;

    // Reset with pins wiggling
    for (int i = 0; i < 5; i++) begin
      {sdata, sclkp, sclkn, senable, supdate, sreset} = 6'(i * 13 + 7);
      wait_cyc(1);
    end
    {sdata, sclkp, sclkn, senable, supdate, sreset} = '0;
    rst_n = 1'b1;
    wait_cyc(12);
    chk("rst_sdata", 128'(o_sdata), 128'(0));
    chk("rst_cfg", 128'(o_cfg), 128'(0));
    chk("rst_upd", 128'(o_cfg_upd), 128'(0));
    chk("rst_err_phase", 128'(o_err_phase), 128'(0));
    chk("rst_err_len", 128'(o_err_len), 128'(0));
    chk("rst_upd_cnt", 128'(upd_cnt), 128'(0));

    // Full scan, then update with exact latency
    scan_word(val, L, cap);
    chk("full_sdata_msb", 128'(o_sdata), 128'(1));
    supdate = 1'b1;
    wait_cyc(3);
    chk("upd_not_early", 128'(o_cfg_upd), 128'(0));
    wait_cyc(1);
    chk("upd_pulse", 128'(o_cfg_upd), 128'(1));
    chk("full_cfg", 128'(o_cfg), 128'(val));
    wait_cyc(1);
    chk("upd_one_cycle", 128'(o_cfg_upd), 128'(0));
    supdate = 1'b0;
    wait_cyc(8);
    chk("full_upd_cnt", 128'(upd_cnt), 128'(1));
    chk("full_err_len", 128'(o_err_len), 128'(0));
    chk("field_en_alu", 128'(o_cfg[BeEnAlu]), 128'(1));
    chk("field_rst_alu", 128'(o_cfg[BeRstAlu]), 128'(0));

    // Readback while shifting zeros
    scan_word('0, L, cap);
    chk("readback", 128'(cap), 128'(val));
    pulse_update();
    chk("readback_cfg", 128'(o_cfg), 128'(0));
    chk("readback_err_len", 128'(o_err_len), 128'(0));

    // Short scan of 50 ones
    scan_word(ones, 50, cap);
    pulse_update();
    exp_v = '0;
    exp_v[49:0] = '1;
    chk("short_err_len", 128'(o_err_len), 128'(1));
    chk("short_cfg", 128'(o_cfg), 128'(exp_v));
    scan_word(val2, L, cap);
    pulse_update();
    chk("rescan_cfg", 128'(o_cfg), 128'(val2));
    chk("rescan_err_len_sticky", 128'(o_err_len), 128'(1));
    chk("pre_phase_err", 128'(o_err_phase), 128'(0));

    // Two sclkp without sclkn: second sample (1) must be committed
    sdata = 1'b0; senable = 1'b1;
    wait_cyc(4); sclkp = 1'b1; wait_cyc(4); sclkp = 1'b0; wait_cyc(4);
    sdata = 1'b1;
    wait_cyc(4); sclkp = 1'b1; wait_cyc(4); sclkp = 1'b0; wait_cyc(4);
    sclkn = 1'b1; wait_cyc(4); sclkn = 1'b0; wait_cyc(4);
    chk("phase_err", 128'(o_err_phase), 128'(1));
    chk("phase_sdata", 128'(o_sdata), 128'(val2[L-2]));
    pulse_update();
    exp_v = {val2[L-2:0], 1'b1};
    chk("phase_cfg", 128'(o_cfg), 128'(exp_v));

    // Soft reset colliding with update
    scan_word(ones, L, cap);
    pulse_update();
    chk("ones_cfg", 128'(o_cfg), 128'(ones));
    upd_base = upd_cnt;
    sreset = 1'b1; supdate = 1'b1;
    wait_cyc(8);
    sreset = 1'b0; supdate = 1'b0;
    wait_cyc(8);
    chk("sreset_cfg", 128'(o_cfg), 128'(0));
    chk("sreset_no_upd", 128'(upd_cnt - upd_base), 128'(0));
    chk("sreset_sdata", 128'(o_sdata), 128'(0));
    chk("sreset_err_phase_sticky", 128'(o_err_phase), 128'(1));
    chk("sreset_err_len_sticky", 128'(o_err_len), 128'(1));

    // senable=0 cycle shifts nothing
    scan_bit(1'b1, 1'b0, so);
    chk("disabled_sdata", 128'(o_sdata), 128'(0));

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
